fifo_stream_reader: RTL
=======================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the word width on both sides.
REQ-002 SHALL have parameter BURST_LEN, default 16, the words per burst; legal range 1..65536.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port f_empty  input  1  empty flag from the read side of a FWFT FIFO.
REQ-006 SHALL have port f_data  input  DATA_WIDTH  the FWFT head word; valid whenever f_empty=0.
REQ-007 SHALL have port f_inc  output  1  pop strobe to the FIFO.
REQ-008 SHALL have port m_valid  output  1  the output word is valid.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  the output word.
REQ-010 SHALL have port m_last  output  1  marks the final word of each BURST_LEN burst.
REQ-011 SHALL have port m_ready  input  1  the downstream consumer accepts the word.

Function
REQ-012 SHALL drive m_valid, m_data and m_last directly from flops, with no combinational path from any input.
REQ-013 SHALL assert f_inc = rst_n && !f_empty && (state != FULL); f_inc SHALL NOT depend on m_ready.
REQ-014 SHALL count a word as accepted on a cycle with f_inc=1, and capture f_data on that same edge.
REQ-015 SHALL count a word as transferred on a cycle with m_valid && m_ready.
REQ-016 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-017 SHALL implement three states: EMPTY (no word held), ONE (output register valid) and FULL (output and skid registers valid).
REQ-018 In EMPTY, an accept SHALL load the output register and move to ONE.
REQ-019 In ONE with accept && m_ready, SHALL load the output register from f_data and stay in ONE.
REQ-020 In ONE with accept && !m_ready, SHALL load the skid register and move to FULL.
REQ-021 In ONE with !accept && m_ready, SHALL move to EMPTY.
REQ-022 In ONE with neither accept nor m_ready, SHALL hold.
REQ-023 In FULL with m_ready, SHALL move the skid register into the output register and move to ONE.
REQ-024 In FULL with !m_ready, SHALL hold.
REQ-025 SHALL sustain one word per cycle in ONE while f_empty=0 and m_ready=1.
REQ-026 SHALL give 1 cycle of latency from the f_inc edge to m_valid.
REQ-027 SHALL keep an ingress burst counter of width max(1,$clog2(BURST_LEN)), incremented on each accept.
REQ-028 When the counter equals BURST_LEN-1 on an accept, SHALL tag that word last=1 and wrap the counter to 0.
REQ-029 SHALL store the last tag alongside each data word in both registers.
REQ-030 With BURST_LEN=1, SHALL set m_last=1 on every word.
REQ-031 SHALL never pop when the FIFO is empty or when the block is in FULL.
REQ-032 SHALL never drop or duplicate a word, and SHALL preserve word order.

Reset
REQ-033 While rst_n=0, SHALL force f_inc=0, m_valid=0, m_last=0, m_data=0, state=EMPTY, burst counter=0 and skid register=0.
REQ-034 Reset mid-burst or in FULL SHALL discard the held words and restart the burst count at 0 on the first word after reset.

Structure
REQ-035 SHALL place the state enum (EMPTY, ONE, FULL) in the shared package stream_pkg.
REQ-036 SHALL be a single flat module with no sub-modules; it instantiates no FIFO itself.

Verification
REQ-037 Bench: FIFO preloaded with 0x01..0x05, m_ready=1 -> m_data 0x01..0x05 on 5 consecutive cycles starting 1 cycle after the first f_inc.
REQ-038 Bench: m_ready=0 with the FIFO non-empty -> exactly 2 pops, then f_inc=0; m_data=first word held stable; on m_ready=1, the second word follows with no gap.
REQ-039 Bench: BURST_LEN=4, 10 words streamed -> m_last=1 on words 4 and 8 only.
REQ-040 Bench: BURST_LEN=1 -> m_last=1 on every word.
REQ-041 Bench: rst_n=0 for 1 cycle while in FULL after 2 words of a 4-word burst -> next cycle m_valid=0; the next word after reset is burst position 0, so m_last falls on the 4th word after reset.
REQ-042 Bench: random f_empty and m_ready over 1000 words -> output sequence equals input sequence, no pop while empty, m_data stable while stalled.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types for the stream reader: skid-buffer state encoding and counter sizing.
package stream_pkg;

    // Occupancy of the output/skid register pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        ONE   = 2'd1,   // output register valid
        FULL  = 2'd2    // output and skid registers valid
    } stream_state_t;

    // Burst counter width: max(1, clog2(burst_len)).
    function automatic int unsigned burst_cnt_width(input int unsigned burst_len);
        return (burst_len <= 1) ? 1 : $clog2(burst_len);
    endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO into a valid/ready stream, tagging the
// final word of every BURST_LEN-word burst with m_last.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : synchronous active-low reset
//   f_empty  : FIFO empty flag (read side)
//   f_data   : FIFO head word, valid whenever f_empty = 0
//   f_inc    : pop strobe to the FIFO
//   m_valid  : output word valid (registered)
//   m_data   : output word (registered)
//   m_last   : last word of a burst (registered)
//   m_ready  : downstream accepts the word
//
// A two-entry skid buffer (output + skid register) lets f_inc be decided without
// looking at m_ready, while still sustaining one word per cycle.
module fifo_stream_reader
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_empty,
    input  logic [DATA_WIDTH-1:0] f_data,
    output logic                  f_inc,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int unsigned CNT_W = burst_cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    stream_state_t         r_state;
    stream_state_t         w_state_nxt;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic [CNT_W-1:0]      r_burst_cnt;

    logic                  w_accept;
    logic                  w_last_in;
    logic                  w_load_out_in;
    logic                  w_load_out_skid;
    logic                  w_load_skid;

    // Pop whenever there is room; m_ready deliberately plays no part here.
    always_comb begin
        w_accept  = rst_n && !f_empty && (r_state != FULL);
        w_last_in = (r_burst_cnt == CNT_LAST);
    end

    assign f_inc = w_accept;

    // Next-state and register-load selects.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_out_in = 1'b1;
                    w_state_nxt   = ONE;
                end
            end
            ONE: begin
                if (w_accept && m_ready) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = FULL;
                end else if (m_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (m_ready) begin
                    w_load_out_skid = 1'b1;
                    w_state_nxt     = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // State register plus output, skid and burst-count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != EMPTY);

            if (w_accept) begin
                r_burst_cnt <= w_last_in ? '0 : r_burst_cnt + CNT_W'(1);
            end

            if (w_load_out_in) begin
                r_data <= f_data;
                r_last <= w_last_in;
            end else if (w_load_out_skid) begin
                r_data <= r_skid_data;
                r_last <= r_skid_last;
            end

            if (w_load_skid) begin
                r_skid_data <= f_data;
                r_skid_last <= w_last_in;
            end
        end
    end

    assign m_valid = r_valid;
    assign m_data  = r_data;
    assign m_last  = r_last;

endmodule
